// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed DATA_WIDTH-cycle latency with a one-cycle Done pulse and held Result.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [2:0]            MulDivOp,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opa_q, opa_d, opb_q, opb_d, rawa_q, rawa_d;
    logic [W-1:0]     result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d, divz_q, divz_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             in_div, a_sgn, b_sgn, accept;
    logic [W-1:0]     mag_a, mag_b, addend, dr;
    logic [W:0]       sum, shifted, diff;
    logic             ge;
    logic [2*W-1:0]   acc_next, prod_s;
    logic [W-1:0]     final_res;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rawa_d   = rawa_q;
        result_d = result_q;
        op_d     = op_q;
        neg_d    = neg_q;
        divz_d   = divz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // Operand preparation for a new request: signedness per op, magnitudes
        in_div = MulDivOp[2];
        a_sgn  = (in_div ? ~MulDivOp[0] : (MulDivOp != 3'b011)) & SrcA[W-1];
        b_sgn  = (in_div ? ~MulDivOp[0] : ~MulDivOp[1]) & SrcB[W-1];
        mag_a  = a_sgn ? -SrcA : SrcA;
        mag_b  = b_sgn ? -SrcB : SrcB;
        accept = Start && (state_q != CALC);

        // Multiply step: conditional add into the upper half, then shift right
        addend = acc_q[0] ? opa_q : '0;
        sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};

        // Divide step: upper half is the partial remainder, lower half shifts in quotient bits
        shifted = acc_q[2*W-1:W-1];
        diff    = shifted - {1'b0, opb_q};
        ge      = ~diff[W];

        if (op_q[2]) begin
            acc_next = {(ge ? diff[W-1:0] : shifted[W-1:0]), acc_q[W-2:0], ge};
        end else begin
            acc_next = {sum, acc_q[W-1:1]};
        end

        prod_s = neg_q ? -acc_next : acc_next;
        dr     = op_q[1] ? acc_next[2*W-1:W] : acc_next[W-1:0];
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
        end else if (divz_q) begin
            final_res = op_q[1] ? rawa_q : '1;
        end else begin
            final_res = neg_q ? -dr : dr;
        end

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = MulDivOp;
                    opa_d   = mag_a;
                    opb_d   = mag_b;
                    rawa_d  = SrcA;
                    divz_d  = (SrcB == '0);
                    neg_d   = (in_div && MulDivOp[1]) ? a_sgn : (a_sgn ^ b_sgn);
                    acc_d   = in_div ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
                end
            end
            CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d  = FIN;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    result_d = final_res;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rawa_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            divz_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rawa_q   <= rawa_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            divz_q   <= divz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latency checks.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          Start = 1'b0;
    logic [2:0]    MulDivOp = 3'b000;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic          Busy, Done;
    logic [W-1:0]  Result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .MulDivOp(MulDivOp),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the RV32M rules using 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, ua, p;
        logic               ovf;
        logic [31:0]        res;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = '0;
        case (op)
            3'd0: begin p = sa * sb; res = p[31:0];  end
            3'd1: begin p = sa * sb; res = p[63:32]; end
            3'd2: begin p = sa * ub; res = p[63:32]; end
            3'd3: begin p = ua * ub; res = p[63:32]; end
            3'd4: begin
                if (b == 0) res = 32'hFFFF_FFFF;
                else if (ovf) res = 32'h8000_0000;
                else begin p = sa / sb; res = p[31:0]; end
            end
            3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) res = a;
                else if (ovf) res = 32'h0;
                else begin p = sa % sb; res = p[31:0]; end
            end
            default: res = (b == 0) ? a : a % b;
        endcase
        return res;
    endfunction

    // Transaction-level model: an accepted request occupies W cycles, then Done for one
    int          rem_cyc;
    logic        exp_done;
    logic [31:0] exp_res, pend_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_cyc  <= 0;
            exp_done <= 1'b0;
            exp_res  <= '0;
            pend_res <= '0;
        end else begin
            exp_done <= 1'b0;
            if (rem_cyc > 0) begin
                rem_cyc <= rem_cyc - 1;
                if (rem_cyc == 1) begin
                    exp_done <= 1'b1;
                    exp_res  <= pend_res;
                end
            end else if (Start) begin
                pend_res <= ref_result(MulDivOp, SrcA, SrcB);
                rem_cyc  <= W;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("model busy",   {31'b0, Busy}, {31'b0, rem_cyc > 0});
            check("model done",   {31'b0, Done}, {31'b0, exp_done});
            check("model result", Result, exp_res);
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int glitch);
        int busy_n;
        int done_at;
        busy_n  = 0;
        done_at = 0;
        MulDivOp = op;
        SrcA     = a;
        SrcB     = b;
        Start    = 1'b1;
        for (int i = 1; i <= W + 8 && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                Start = 1'b0;
                SrcA  = ~a;
                SrcB  = b + 32'd1;
            end
            if (glitch != 0 && i == glitch) begin
                Start    = 1'b1;
                MulDivOp = 3'b101;
            end
            if (glitch != 0 && i == glitch + 1) Start = 1'b0;
            if (Busy) busy_n++;
            if (Done) done_at = i;
        end
        check({name, " latency"}, done_at, W + 1);
        check({name, " busy cycles"}, busy_n, W);
        check({name, " result"}, Result, exp);
    endtask

    initial begin
        int dcount;
        int d1, d2;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, Busy}, 32'd0);
        check("reset done", {31'b0, Done}, 32'd0);
        check("reset result", Result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);

        // Reset in the middle of an operation discards it
        @(negedge clk);
        MulDivOp = 3'b000; SrcA = 32'd3; SrcB = 32'd4; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, Busy}, 32'd0);
        check("midreset done", {31'b0, Done}, 32'd0);
        check("midreset result", Result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) dcount++;
        end
        check("midreset no done", dcount, 0);

        run_op("mul 3x4", 3'b000, 32'd3, 32'd4, 32'h0000_000C, 0);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 0);
        run_op("remu 100/7", 3'b111, 32'd100, 32'd7, 32'h0000_0002, 0);
        run_op("divu 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu 5/0", 3'b111, 32'd5, 32'd0, 32'h0000_0005, 0);
        run_op("div -5/0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("rem -5/0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
        run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

        // Back-to-back: Start held high through FIN queues the DIV behind the MUL
        @(negedge clk);
        MulDivOp = 3'b000; SrcA = 32'd6; SrcB = 32'd7; Start = 1'b1;
        d1 = 0;
        d2 = 0;
        for (int i = 1; i <= 100 && d2 == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                MulDivOp = 3'b100; SrcA = 32'd20; SrcB = 32'd3;
            end
            if (Done) begin
                if (d1 == 0) begin
                    d1 = i;
                    check("b2b first result", Result, 32'h0000_002A);
                end else begin
                    d2 = i;
                    check("b2b second result", Result, 32'h0000_0006);
                end
            end
            if (d1 != 0 && i == d1 + 1) Start = 1'b0;
            if (d1 != 0 && d2 == 0 && i == d1 + 16) check("b2b hold", Result, 32'h0000_002A);
        end
        Start = 1'b0;
        check("b2b first latency", d1, W + 1);
        check("b2b spacing", d2 - d1, W + 1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
